// File: rtl/pipe_mips32_fwd.sv
// Single-clock five-stage MIPS32 pipeline with full forwarding, load-use interlock,
// EX-resolved branches with flush, unified word memory and a program-load port.
module pipe_mips32_fwd #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned MEM_DEPTH = 1024,
  parameter int unsigned AW        = $clog2(MEM_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            ld_we,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data,
  output logic            halted,
  output logic [AW-1:0]   debug_pc,
  output logic [31:0]     retired,
  output logic [31:0]     stall_cycles
);

  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;
  localparam int unsigned IW   = 32;
  localparam int unsigned CW   = 32;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
    OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW,
    OP_BNEQZ, OP_BEQZ, OP_HLT
  } op_e;

  typedef struct packed {
    logic          valid;
    logic [IW-1:0] ir;
    logic [AW-1:0] npc;
  } ifid_t;

  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   dest;
    logic            we;
    logic [AW-1:0]   npc;
  } idex_t;

  typedef struct packed {
    logic            valid;
    op_e             op;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] sdata;
    logic [RW-1:0]   dest;
    logic            we;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic            hlt;
    logic [XLEN-1:0] val;
    logic [RW-1:0]   dest;
    logic            we;
  } memwb_t;

  logic [XLEN-1:0] mem  [MEM_DEPTH];
  logic [XLEN-1:0] regs [NREG];

  logic [AW-1:0] pc;
  ifid_t         ifid;
  idex_t         idex, idex_n;
  exmem_t        exm, exm_n;
  memwb_t        mwb, mwb_n;
  logic          hlt_seen;

  logic            advance;
  logic [XLEN-1:0] if_word;
  op_e             id_op;
  logic            id_use_rs, id_use_rt, id_writes;
  logic [RW-1:0]   id_rs, id_rt, id_rd, id_dest;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  logic            id_hlt, fetch_block, stall;
  logic            wb_fwd, exm_fwd;
  logic [XLEN-1:0] ex_a, ex_b, ex_alu;
  logic            br_taken;
  logic [AW-1:0]   br_target;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  assign advance  = run & ~halted;
  assign debug_pc = pc;
  assign if_word  = mem[pc];

  assign id_rs  = ifid.ir[25:21];
  assign id_rt  = ifid.ir[20:16];
  assign id_rd  = ifid.ir[15:11];
  assign id_imm = {{(XLEN-16){ifid.ir[15]}}, ifid.ir[15:0]};

  // Decode: opcode class, which source fields are read, and destination.
  always_comb begin
    id_op     = OP_HLT;
    id_use_rs = 1'b0;
    id_use_rt = 1'b0;
    id_writes = 1'b0;
    id_dest   = '0;
    case (ifid.ir[31:26])
      6'b000000: id_op = OP_ADD;
      6'b000001: id_op = OP_SUB;
      6'b000010: id_op = OP_AND;
      6'b000011: id_op = OP_OR;
      6'b000100: id_op = OP_SLT;
      6'b000101: id_op = OP_MUL;
      6'b001010: id_op = OP_ADDI;
      6'b001011: id_op = OP_SUBI;
      6'b001100: id_op = OP_SLTI;
      6'b001000: id_op = OP_LW;
      6'b001001: id_op = OP_SW;
      6'b001101: id_op = OP_BNEQZ;
      6'b001110: id_op = OP_BEQZ;
      default:   id_op = OP_HLT;
    endcase
    case (id_op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: begin
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
        id_writes = 1'b1;
        id_dest   = id_rd;
      end
      OP_ADDI, OP_SUBI, OP_SLTI, OP_LW: begin
        id_use_rs = 1'b1;
        id_writes = 1'b1;
        id_dest   = id_rt;
      end
      OP_SW: begin
        id_use_rs = 1'b1;
        id_use_rt = 1'b1;
      end
      OP_BNEQZ, OP_BEQZ: id_use_rs = 1'b1;
      default: ;
    endcase
  end

  assign wb_fwd  = mwb.valid & mwb.we;
  assign exm_fwd = exm.valid & exm.we & (exm.op != OP_LW);

  // Register read with write-through from WB; R0 always reads zero.
  always_comb begin
    id_a = regs[id_rs];
    id_b = regs[id_rt];
    if (wb_fwd && mwb.dest == id_rs) id_a = mwb.val;
    if (wb_fwd && mwb.dest == id_rt) id_b = mwb.val;
    if (id_rs == '0) id_a = '0;
    if (id_rt == '0) id_b = '0;
  end

  assign id_hlt      = ifid.valid & (id_op == OP_HLT);
  assign fetch_block = hlt_seen | id_hlt;
  assign stall       = ifid.valid & idex.valid & (idex.op == OP_LW) & idex.we &
                       ((id_use_rs & (id_rs == idex.dest)) |
                        (id_use_rt & (id_rt == idex.dest)));

  always_comb begin
    idex_n       = '0;
    idex_n.valid = ifid.valid;
    idex_n.op    = id_op;
    idex_n.a     = id_a;
    idex_n.b     = id_b;
    idex_n.imm   = id_imm;
    idex_n.rs    = id_rs;
    idex_n.rt    = id_rt;
    idex_n.dest  = id_dest;
    idex_n.we    = id_writes & (id_dest != '0);
    idex_n.npc   = ifid.npc;
  end

  // EX operand forwarding: EX/MEM result wins over MEM/WB.
  always_comb begin
    ex_a = idex.a;
    ex_b = idex.b;
    if (exm_fwd && exm.dest == idex.rs)      ex_a = exm.alu;
    else if (wb_fwd && mwb.dest == idex.rs)  ex_a = mwb.val;
    if (exm_fwd && exm.dest == idex.rt)      ex_b = exm.alu;
    else if (wb_fwd && mwb.dest == idex.rt)  ex_b = mwb.val;
  end

  always_comb begin
    ex_alu = '0;
    case (idex.op)
      OP_ADD:       ex_alu = ex_a + ex_b;
      OP_SUB:       ex_alu = ex_a - ex_b;
      OP_AND:       ex_alu = ex_a & ex_b;
      OP_OR:        ex_alu = ex_a | ex_b;
      OP_SLT:       ex_alu = XLEN'(ex_a < ex_b);
      OP_MUL:       ex_alu = ex_a * ex_b;
      OP_ADDI:      ex_alu = ex_a + idex.imm;
      OP_SUBI:      ex_alu = ex_a - idex.imm;
      OP_SLTI:      ex_alu = XLEN'(ex_a < idex.imm);
      OP_LW, OP_SW: ex_alu = ex_a + idex.imm;
      default:      ex_alu = '0;
    endcase
  end

  assign br_taken  = idex.valid & (((idex.op == OP_BEQZ) & (ex_a == '0)) |
                                   ((idex.op == OP_BNEQZ) & (ex_a != '0)));
  assign br_target = idex.npc + idex.imm[AW-1:0];

  always_comb begin
    exm_n       = '0;
    exm_n.valid = idex.valid;
    exm_n.op    = idex.op;
    exm_n.alu   = ex_alu;
    exm_n.sdata = ex_b;
    exm_n.dest  = idex.dest;
    exm_n.we    = idex.we;
  end

  assign mem_rdata = mem[exm.alu[AW-1:0]];

  always_comb begin
    mwb_n       = '0;
    mwb_n.valid = exm.valid;
    mwb_n.hlt   = exm.op == OP_HLT;
    mwb_n.val   = (exm.op == OP_LW) ? mem_rdata : exm.alu;
    mwb_n.dest  = exm.dest;
    mwb_n.we    = exm.we;
  end

  // Load port owns the memory write port whenever the core is stopped.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = exm.alu[AW-1:0];
    mem_wdata = exm.sdata;
    if (!run) begin
      mem_we    = ld_we;
      mem_waddr = ld_addr;
      mem_wdata = ld_data;
    end else begin
      mem_we = advance & exm.valid & (exm.op == OP_SW);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (advance && mwb.valid && mwb.we) regs[mwb.dest] <= mwb.val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc           <= '0;
      ifid         <= '0;
      idex         <= '0;
      exm          <= '0;
      mwb          <= '0;
      hlt_seen     <= 1'b0;
      halted       <= 1'b0;
      retired      <= '0;
      stall_cycles <= '0;
    end else if (advance) begin
      exm <= exm_n;
      mwb <= mwb_n;
      if (br_taken) begin
        pc   <= br_target;
        ifid <= '0;
        idex <= '0;
      end else if (stall) begin
        idex         <= '0;
        stall_cycles <= stall_cycles + CW'(1);
      end else begin
        idex <= idex_n;
        if (id_hlt) hlt_seen <= 1'b1;
        if (fetch_block) begin
          ifid <= '0;
        end else begin
          ifid.valid <= 1'b1;
          ifid.ir    <= if_word[IW-1:0];
          ifid.npc   <= pc + AW'(1);
          pc         <= pc + AW'(1);
        end
      end
      if (mwb.valid) retired <= retired + CW'(1);
      if (mwb.valid && mwb.hlt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed bench for pipe_mips32_fwd: table of per-program expected results plus
// hand sequences for run-freeze and asynchronous reset mid-program.
module tb_pipe_mips32_fwd;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_DEPTH = 1024;
  localparam int unsigned AW        = 10;
  localparam int NSCEN  = 5;
  localparam int MAXW   = 12;
  localparam int BUDGET = 300;
  localparam int K_REG = 0, K_MEM = 1, K_RET = 2, K_STALL = 3, K_CYC = 4, K_PC = 5;

  localparam logic [5:0] O_ADD = 6'b000000, O_SUB = 6'b000001, O_AND = 6'b000010;
  localparam logic [5:0] O_OR = 6'b000011, O_SLT = 6'b000100, O_MUL = 6'b000101;
  localparam logic [5:0] O_ADDI = 6'b001010, O_SUBI = 6'b001011, O_SLTI = 6'b001100;
  localparam logic [5:0] O_LW = 6'b001000, O_SW = 6'b001001;
  localparam logic [5:0] O_BNEQZ = 6'b001101, O_BEQZ = 6'b001110;
  localparam logic [31:0] W_HLT = 32'hFC00_0000;

  typedef struct {
    int          scen;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } chk_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            run = 1'b0;
  logic            ld_we = 1'b0;
  logic [AW-1:0]   ld_addr = '0;
  logic [XLEN-1:0] ld_data = '0;
  logic            halted;
  logic [AW-1:0]   debug_pc;
  logic [31:0]     retired;
  logic [31:0]     stall_cycles;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] prog [NSCEN][MAXW];
  int          plen [NSCEN];
  chk_t        tbl [$];

  pipe_mips32_fwd #(.XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .halted(halted), .debug_pc(debug_pc), .retired(retired),
    .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
    return {op, rs, rt, rd, 11'b0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] actual(input int kind, input int idx, input int cyc);
    case (kind)
      K_REG:   return dut.regs[5'(idx)];
      K_MEM:   return dut.mem[10'(idx)];
      K_RET:   return retired;
      K_STALL: return stall_cycles;
      K_CYC:   return 32'(cyc);
      default: return 32'(debug_pc);
    endcase
  endfunction

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    run   = 1'b0;
    ld_we = 1'b0;
    #1;
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_pc", 32'(debug_pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_word(input int addr, input logic [31:0] data);
    ld_addr = AW'(addr);
    ld_data = data;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  task automatic load_scen(input int s);
    for (int i = 0; i < plen[s]; i++) load_word(i, prog[s][i]);
    load_word(100, 32'd7);
    load_word(101, 32'd0);
    load_word(200, 32'd0);
  endtask

  task automatic run_to_halt(output int cyc);
    run = 1'b1;
    cyc = 0;
    while (halted !== 1'b1 && cyc < BUDGET) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (halted !== 1'b1) begin
      n_chk++;
      n_err++;
      $display("FAIL halt_timeout: got no halt expected halt within %0d cycles", BUDGET);
    end
  endtask

  initial begin
    int cyc;

    // Forward chain
    prog[0][0] = enc_i(O_ADDI, 5'd0, 5'd1, 16'd10);
    prog[0][1] = enc_r(O_ADD, 5'd1, 5'd1, 5'd2);
    prog[0][2] = enc_r(O_SUB, 5'd2, 5'd1, 5'd3);
    prog[0][3] = W_HLT;
    plen[0] = 4;
    // Load-use
    prog[1][0] = enc_i(O_LW, 5'd0, 5'd4, 16'd100);
    prog[1][1] = enc_r(O_ADD, 5'd4, 5'd4, 5'd5);
    prog[1][2] = enc_i(O_SW, 5'd0, 5'd5, 16'd101);
    prog[1][3] = W_HLT;
    plen[1] = 4;
    // Branch loop with shadow slot
    prog[2][0] = enc_i(O_ADDI, 5'd0, 5'd1, 16'd3);
    prog[2][1] = enc_i(O_SUBI, 5'd1, 5'd1, 16'd1);
    prog[2][2] = enc_i(O_BNEQZ, 5'd1, 5'd0, 16'hFFFE);
    prog[2][3] = enc_i(O_ADDI, 5'd0, 5'd2, 16'd9);
    prog[2][4] = W_HLT;
    plen[2] = 5;
    // R0 behaviour, unknown opcode acts as HLT
    prog[3][0] = enc_i(O_ADDI, 5'd0, 5'd6, 16'd33);
    prog[3][1] = enc_i(O_ADDI, 5'd0, 5'd0, 16'd5);
    prog[3][2] = enc_r(O_ADD, 5'd0, 5'd0, 5'd6);
    prog[3][3] = 32'h5400_0000;
    prog[3][4] = enc_i(O_ADDI, 5'd0, 5'd6, 16'd44);
    plen[3] = 5;
    // ALU mix, unsigned compares, MUL, taken BEQZ skipping one word
    prog[4][0]  = enc_i(O_ADDI, 5'd0, 5'd1, 16'hFFFD);
    prog[4][1]  = enc_i(O_ADDI, 5'd0, 5'd2, 16'd5);
    prog[4][2]  = enc_r(O_SLT, 5'd1, 5'd2, 5'd3);
    prog[4][3]  = enc_i(O_SLTI, 5'd2, 5'd4, 16'hFFFF);
    prog[4][4]  = enc_r(O_MUL, 5'd1, 5'd2, 5'd5);
    prog[4][5]  = enc_r(O_AND, 5'd1, 5'd2, 5'd6);
    prog[4][6]  = enc_r(O_OR, 5'd1, 5'd2, 5'd7);
    prog[4][7]  = enc_i(O_SUBI, 5'd2, 5'd9, 16'd7);
    prog[4][8]  = enc_i(O_BEQZ, 5'd0, 5'd0, 16'd1);
    prog[4][9]  = enc_i(O_ADDI, 5'd0, 5'd6, 16'd99);
    prog[4][10] = W_HLT;
    plen[4] = 11;

    tbl.push_back('{0, K_REG, 1, 32'd10});
    tbl.push_back('{0, K_REG, 2, 32'd20});
    tbl.push_back('{0, K_REG, 3, 32'd10});
    tbl.push_back('{0, K_RET, 0, 32'd4});
    tbl.push_back('{0, K_STALL, 0, 32'd0});
    tbl.push_back('{0, K_CYC, 0, 32'd8});
    tbl.push_back('{0, K_PC, 0, 32'd4});
    tbl.push_back('{1, K_MEM, 101, 32'd14});
    tbl.push_back('{1, K_REG, 5, 32'd14});
    tbl.push_back('{1, K_STALL, 0, 32'd1});
    tbl.push_back('{1, K_RET, 0, 32'd4});
    tbl.push_back('{1, K_CYC, 0, 32'd9});
    tbl.push_back('{1, K_PC, 0, 32'd4});
    tbl.push_back('{2, K_REG, 1, 32'd0});
    tbl.push_back('{2, K_REG, 2, 32'd9});
    tbl.push_back('{2, K_RET, 0, 32'd9});
    tbl.push_back('{2, K_STALL, 0, 32'd0});
    tbl.push_back('{2, K_CYC, 0, 32'd17});
    tbl.push_back('{2, K_PC, 0, 32'd5});
    tbl.push_back('{3, K_REG, 6, 32'd0});
    tbl.push_back('{3, K_RET, 0, 32'd4});
    tbl.push_back('{3, K_STALL, 0, 32'd0});
    tbl.push_back('{3, K_CYC, 0, 32'd8});
    tbl.push_back('{3, K_PC, 0, 32'd4});
    tbl.push_back('{4, K_REG, 3, 32'd0});
    tbl.push_back('{4, K_REG, 4, 32'd1});
    tbl.push_back('{4, K_REG, 5, 32'hFFFF_FFF1});
    tbl.push_back('{4, K_REG, 6, 32'd5});
    tbl.push_back('{4, K_REG, 7, 32'hFFFF_FFFD});
    tbl.push_back('{4, K_REG, 9, 32'hFFFF_FFFE});
    tbl.push_back('{4, K_RET, 0, 32'd10});
    tbl.push_back('{4, K_CYC, 0, 32'd16});
    tbl.push_back('{4, K_PC, 0, 32'd11});

    // Run each program; the few extra run=1 cycles confirm the post-halt freeze.
    for (int s = 0; s < NSCEN; s++) begin
      do_reset;
      load_scen(s);
      run_to_halt(cyc);
      repeat (3) @(negedge clk);
      check($sformatf("s%0d_halted", s), 32'(halted), 32'd1);
      foreach (tbl[i]) begin
        if (tbl[i].scen == s)
          check($sformatf("s%0d_kind%0d_idx%0d", s, tbl[i].kind, tbl[i].idx),
                actual(tbl[i].kind, tbl[i].idx, cyc), tbl[i].exp);
      end
      run = 1'b0;
    end

    // Freeze after the load-use stall, write Mem[200] through the load port, resume.
    do_reset;
    load_scen(1);
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    run = 1'b0;
    check("frz_pc_enter", 32'(debug_pc), 32'd2);
    check("frz_ret_enter", retired, 32'd0);
    check("frz_stall_enter", stall_cycles, 32'd1);
    load_word(200, 32'h55);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("frz_pc_%0d", k), 32'(debug_pc), 32'd2);
    end
    check("frz_ret_hold", retired, 32'd0);
    check("frz_stall_hold", stall_cycles, 32'd1);
    run_to_halt(cyc);
    check("frz_cyc_rest", 32'(cyc), 32'd6);
    check("frz_mem101", dut.mem[10'd101], 32'd14);
    check("frz_mem200", dut.mem[10'd200], 32'h55);
    check("frz_ret", retired, 32'd4);
    check("frz_stall", stall_cycles, 32'd1);
    run = 1'b0;

    // Async reset while the SW sits in MEM, then rerun from PC 0.
    do_reset;
    load_scen(1);
    run = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("ar_pre_ret", retired, 32'd1);
    check("ar_pre_stall", stall_cycles, 32'd1);
    check("ar_pre_pc", 32'(debug_pc), 32'd4);
    rst_n = 1'b0;
    run   = 1'b0;
    #1;
    check("ar_pc", 32'(debug_pc), 32'd0);
    check("ar_ret", retired, 32'd0);
    check("ar_stall", stall_cycles, 32'd0);
    check("ar_halted", 32'(halted), 32'd0);
    repeat (2) @(negedge clk);
    check("ar_mem101_kept", dut.mem[10'd101], 32'd0);
    rst_n = 1'b1;
    run_to_halt(cyc);
    check("ar_rerun_cyc", 32'(cyc), 32'd9);
    check("ar_rerun_mem101", dut.mem[10'd101], 32'd14);
    check("ar_rerun_ret", retired, 32'd4);
    run = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
